csa_shared_add_sequencer: RTL and testbench

- Shares one 4-bit carry_select_adder (ports a, b, cin, sum, cout) between two requesters.
- Each accepted request is a WIDTH-bit add. The block runs it nibble by nibble through the shared adder, LSB nibble first, chaining the carry between nibbles.
- Requesters use a valid/ready handshake. Arbitration between them is round-robin.
- The result leaves on a single valid/ready output channel, tagged with the requester id.

---
 rtl/csa_shared_add_sequencer_if.sv | 40 ++++
 rtl/csa_shared_add_sequencer.sv | 145 ++++++++++++++
 tb/tb_csa_shared_add_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_shared_add_sequencer_if.sv
// rtl/csa_shared_add_sequencer_if.sv - requester and result channels of the shared-adder sequencer
interface csa_shared_add_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  res_valid, res_id, res_sum, res_cout,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output res_valid, res_id, res_sum, res_cout,
    input  res_ready
  );
endinterface

// File: rtl/csa_shared_add_sequencer.sv
// rtl/csa_shared_add_sequencer.sv - two requesters share one 4-bit carry-select adder, nibble-serial
module carry_select_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [1:0] lo_s;
  logic       lo_c;
  logic [1:0] hi_s0;
  logic [1:0] hi_s1;
  logic       hi_c0;
  logic       hi_c1;

  function automatic logic [2:0] add2(input logic [1:0] x, input logic [1:0] y, input logic c);
    logic       c1;
    logic [1:0] s;
    s[0] = x[0] ^ y[0] ^ c;
    c1   = (x[0] & y[0]) | (c & (x[0] ^ y[0]));
    s[1] = x[1] ^ y[1] ^ c1;
    return {(x[1] & y[1]) | (c1 & (x[1] ^ y[1])), s};
  endfunction

  // Upper pair is precomputed for both carries and picked by the lower carry.
  assign {lo_c, lo_s}   = add2(a[1:0], b[1:0], cin);
  assign {hi_c0, hi_s0} = add2(a[3:2], b[3:2], 1'b0);
  assign {hi_c1, hi_s1} = add2(a[3:2], b[3:2], 1'b1);
  assign sum  = {(lo_c ? hi_s1 : hi_s0), lo_s};
  assign cout = lo_c ? hi_c1 : hi_c0;
endmodule

module csa_shared_add_sequencer #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  csa_shared_add_sequencer_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;
  logic             carry;
  logic             last_grant;
  logic [CW-1:0]    nib_cnt;

  logic             res_valid;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  logic             gnt_any;
  logic             gnt_id;
  logic             take;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic [3:0]       add_sum;
  logic             add_cout;

  // Round-robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt_any = bus.req0_valid | bus.req1_valid;
    gnt_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_grant;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign take           = rst_n && (state == IDLE) && gnt_any;
  assign bus.req0_ready = take && !gnt_id;
  assign bus.req1_ready = take && gnt_id;

  assign add_a = op_a[4*nib_cnt +: 4];
  assign add_b = op_b[4*nib_cnt +: 4];

  carry_select_adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= 1'b0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      nib_cnt    <= '0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_a       <= gnt_id ? bus.req1_a : bus.req0_a;
            op_b       <= gnt_id ? bus.req1_b : bus.req0_b;
            carry      <= gnt_id ? bus.req1_cin : bus.req0_cin;
            op_id      <= gnt_id;
            last_grant <= gnt_id;
            nib_cnt    <= '0;
            state      <= CALC;
          end
        end
        CALC: begin
          res_sum[4*nib_cnt +: 4] <= add_sum;
          carry                   <= add_cout;
          nib_cnt                 <= nib_cnt + CW'(1);
          if (nib_cnt == LAST) begin
            res_cout  <= add_cout;
            res_id    <= op_id;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid;
  assign bus.res_id    = res_id;
  assign bus.res_sum   = res_sum;
  assign bus.res_cout  = res_cout;
endmodule

// File: tb/tb_csa_shared_add_sequencer.sv
// tb/tb_csa_shared_add_sequencer.sv - scoreboard bench for the shared-adder sequencer
module tb_csa_shared_add_sequencer;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    int           acc;
  } exp_t;

  typedef struct {
    logic id;
    int   edge_n;
  } acc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_q = 1'b0;
  int   cyc   = 0;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;
  int   hs_edge = 0;
  bit   was_valid = 0;
  bit   acc0 = 0;
  bit   acc1 = 0;
  bit   gap = 0;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];
  acc_t acc_log[$];

  csa_shared_add_sequencer_if #(.WIDTH(W)) bus ();

  csa_shared_add_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    op_t o;
    o.a   = a;
    o.b   = b;
    o.cin = cin;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a   = W'($urandom);
    o.b   = W'($urandom);
    o.cin = 1'($urandom);
    if ($urandom_range(7) == 0) o.a = '1;
    return o;
  endfunction

  // Reference: plain unsigned addition; the result follows accept order.
  task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t        e;
    acc_t        l;
    logic [W:0]  s;
    s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = id;
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.acc  = cyc + 1;
    sb.push_back(e);
    l.id     = id;
    l.edge_n = cyc + 1;
    acc_log.push_back(l);
  endtask

  // Monitor: observes accepts and results at the falling edge.
  always @(negedge clk) begin
    acc0 = 0;
    acc1 = 0;
    if (!rst_n) begin
      sb.delete();
      was_valid = 0;
      check("rst_req0_ready", bus.req0_ready, 0);
      check("rst_req1_ready", bus.req1_ready, 0);
      if (!rst_q) begin
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_sum", bus.res_sum, 0);
        check("rst_res_cout", bus.res_cout, 0);
        check("rst_res_id", bus.res_id, 0);
      end
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        push_exp(1'b0, bus.req0_a, bus.req0_b, bus.req0_cin);
        acc0 = 1;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        push_exp(1'b1, bus.req1_a, bus.req1_b, bus.req1_cin);
        acc1 = 1;
      end
      if (bus.res_valid) begin
        check("hold_req0_ready", bus.req0_ready, 0);
        check("hold_req1_ready", bus.req1_ready, 0);
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          if (!was_valid) check("latency", 64'(cyc - sb[0].acc), NIB);
          check("res_id", bus.res_id, sb[0].id);
          check("res_sum", bus.res_sum, sb[0].sum);
          check("res_cout", bus.res_cout, sb[0].cout);
          if (bus.res_ready) begin
            void'(sb.pop_front());
            n_done++;
            hs_edge   = cyc + 1;
            was_valid = 0;
          end else begin
            was_valid = 1;
          end
        end
      end else begin
        was_valid = 0;
      end
    end
  end

  // Requester drivers: present queue heads, optionally with random valid gaps.
  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_cin   = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_cin   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      bus.req0_valid = (q0.size() != 0) && (!gap || $urandom_range(3) != 0);
      bus.req1_valid = (q1.size() != 0) && (!gap || $urandom_range(3) != 0);
      if (q0.size() != 0) begin
        bus.req0_a   = q0[0].a;
        bus.req0_b   = q0[0].b;
        bus.req0_cin = q0[0].cin;
      end
      if (q1.size() != 0) begin
        bus.req1_a   = q1[0].a;
        bus.req1_b   = q1[0].b;
        bus.req1_cin = q1[0].cin;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0) && n < max) begin
      tick(1);
      n++;
    end
    check(name, 64'(q0.size() + q1.size() + sb.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d;
    int h;
    bus.res_ready = 1'b1;

    // Ties from reset, single op, full carry ripple.
    q0.push_back(mk(16'h000B, 16'h0003, 1'b1));
    q0.push_back(mk(16'h0003, 16'h0004, 1'b0));
    q1.push_back(mk(16'h0005, 16'h0007, 1'b0));
    q1.push_back(mk(16'hFFFF, 16'h0001, 1'b0));
    tick(4);
    rst_n = 1'b1;
    wait_drain("drain_tie", 200);
    check("tie_accepts", 64'(acc_log.size()), 4);
    if (acc_log.size() >= 4) begin
      check("tie_first_id", acc_log[0].id, 0);
      check("tie_second_id", acc_log[1].id, 1);
      check("tie_spacing", 64'(acc_log[1].edge_n - acc_log[0].edge_n), NIB + 2);
      check("tie_third_id", acc_log[2].id, 0);
      check("tie_fourth_id", acc_log[3].id, 1);
    end

    // Backpressure in HOLD, then next accept right after the handoff.
    acc_log.delete();
    bus.res_ready = 1'b0;
    q0.push_back(mk(16'h1234, 16'h1111, 1'b0));
    n = 0;
    while (!bus.res_valid && n < 50) begin
      tick(1);
      n++;
    end
    check("bp_valid_seen", bus.res_valid, 1);
    q1.push_back(mk(16'h00FF, 16'h0F01, 1'b1));
    tick(5);
    d = n_done;
    bus.res_ready = 1'b1;
    n = 0;
    while (n_done == d && n < 20) begin
      tick(1);
      n++;
    end
    h = hs_edge;
    wait_drain("drain_bp", 100);
    check("bp_next_accept", (acc_log.size() == 2) ? 64'(acc_log[1].edge_n) : 64'(0), 64'(h + 1));

    // Reset two cycles into a calculation aborts it.
    acc_log.delete();
    d = n_done;
    q0.push_back(mk(16'h1234, 16'h4321, 1'b0));
    n = 0;
    while (acc_log.size() == 0 && n < 50) begin
      tick(1);
      n++;
    end
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(NIB + 4);
    check("abort_no_result", 64'(n_done), 64'(d));
    q0.push_back(mk(16'h1234, 16'h4321, 1'b0));
    wait_drain("drain_retry", 100);
    check("abort_retry_done", 64'(n_done), 64'(d + 1));

    // Random traffic with valid gaps and random backpressure.
    gap = 1;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      bus.res_ready = ($urandom_range(3) != 0);
      if ($urandom_range(11) == 0) q0.push_back(rand_op());
      if ($urandom_range(11) == 0) q1.push_back(rand_op());
    end
    bus.res_ready = 1'b1;
    wait_drain("drain_random", 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
